oled_spi_driver: RTL
====================

OLED_SPI_DRIVER -- requirements
Module: oled_spi_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8: clk cycles per SCLK half-period (100 MHz clk gives 6.25 MHz SCLK).
REQ-002 SHALL have parameter RESET_CYCLES, default 1000: clk cycles res_n is held low after power-up.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1000: clk cycles to wait after res_n rises before init.
REQ-004 SHALL have port clk, input, 1: the single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port pixel_data, input, 16: RGB565 pixel for the current pixel_index, valid combinationally.
REQ-007 SHALL have port pixel_index, output, 14: raster index 0..6143 (x = idx mod 96, y = idx div 96).
REQ-008 SHALL have port sclk, output, 1: SPI clock, idle low (mode 0).
REQ-009 SHALL have port mosi, output, 1: SPI data, MSB first.
REQ-010 SHALL have port cs_n, output, 1: chip select, active low.
REQ-011 SHALL have port dc, output, 1: 0 = command byte, 1 = pixel data byte.
REQ-012 SHALL have port res_n, output, 1: OLED reset, active low.
REQ-013 SHALL have port frame_begin, output, 1: one-clk pulse when transmission of pixel 0 starts.
REQ-014 SHALL have port ready, output, 1: high once init is complete, then stays high until reset.

Function
REQ-015 SHALL run FSM states PWR_RST -> PWR_WAIT -> INIT -> GAP -> FRAME -> GAP -> FRAME ... and never return to PWR_RST except on rst.
REQ-016 SHALL hold res_n=0 for RESET_CYCLES clk in PWR_RST, then res_n=1 for the rest of operation; PWR_WAIT lasts SETTLE_CYCLES clk.
REQ-017 SHALL in INIT send these 10 bytes with dc=0, in order: AE, A0, 72, 15, 00, 5F, 75, 00, 3F, AF (hex).
REQ-018 SHALL in FRAME send 6144 pixels with dc=1, each as 2 bytes: pixel_data[15:8], then pixel_data[7:0].
REQ-019 SHALL drive mosi on the falling SCLK edge (or at the start of a byte) so it is stable on every rising edge; each SCLK phase lasts exactly CLK_DIV clk.
REQ-020 SHALL hold cs_n low for all bytes of INIT and of a FRAME, with no SCLK gap between consecutive bytes.
REQ-021 SHALL drive cs_n high, sclk low and mosi low for exactly 2*CLK_DIV clk in GAP.
REQ-022 SHALL capture pixel_data into a 16-bit shift register in the clk cycle before the pixel's first SCLK edge, and increment pixel_index in the next clk cycle.
REQ-023 SHALL therefore hold pixel_index stable for at least 16 SCLK periods before each capture.
REQ-024 SHALL wrap pixel_index from 6143 to 0 after the last pixel of a frame, then enter GAP.
REQ-025 SHALL pulse frame_begin for one clk, coincident with the capture of pixel 0.
REQ-026 SHALL set ready on entry to the first GAP after INIT.
REQ-027 SHALL size counters exactly: 4-bit bit counter (0..15), 14-bit pixel counter, 4-bit init byte index, divider counter width from CLK_DIV.
REQ-028 SHALL sample pixel_data only at the capture instants; changes at other times have no effect on transmitted bytes.

Reset
REQ-029 SHALL on rst high immediately (asynchronously) set: state PWR_RST, res_n=0, cs_n=1, sclk=0, mosi=0, dc=0, pixel_index=0, frame_begin=0, ready=0, all counters 0.
REQ-030 SHALL, if rst is asserted mid-byte or mid-frame, abort the transfer with no partial completion and restart the full power-up and init sequence after rst is released.

Verification
REQ-031 SHALL test: CLK_DIV=2, RESET_CYCLES=4, SETTLE_CYCLES=4, pulse rst -> res_n low for 4 clk, then 4 clk wait, then INIT byte stream decoded on sclk rising edges = AE A0 72 15 00 5F 75 00 3F AF with dc=0 and cs_n low.
REQ-032 SHALL test: pixel_data tied to F800 -> every frame byte pair decodes to F8,00 with dc=1; first mosi bit after frame_begin is 1.
REQ-033 SHALL test: pixel_data = {2'b0, pixel_index} -> decoded word n equals n for n = 0..6143, and 6144 words are sent per frame.
REQ-034 SHALL test: across the frame boundary -> pixel_index goes from 6143 to 0, cs_n is high for 4 clk (GAP), and frame_begin pulses exactly once per frame.
REQ-035 SHALL test: rst asserted at pixel 3000, bit 7 -> all outputs reach their reset values in the same cycle and ready=0; after release, the full INIT byte sequence repeats.
REQ-036 SHALL test: SCLK period measured as 4 clk throughout, and mosi never changes within ±1 clk of a rising sclk edge.

Source files
------------

// File: rtl/oled_spi_driver.sv
// oled_spi_driver: power-up, init and continuous raster streaming
// to a 96x64 RGB565 OLED over a write-only mode-0 SPI link.
module oled_spi_driver #(
    parameter int CLK_DIV       = 8,
    parameter int RESET_CYCLES  = 1000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int PIXELS        = 6144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pixel_data,
    output logic [13:0] pixel_index,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        dc,
    output logic        res_n,
    output logic        frame_begin,
    output logic        ready
);

    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int W1   = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int WMAX = (W1 > 2 * CLK_DIV) ? W1 : 2 * CLK_DIV;
    localparam int WW   = $clog2(WMAX + 1);

    localparam logic [DW-1:0] DIV_END  = DW'(CLK_DIV - 1);
    localparam logic [WW-1:0] RST_END  = WW'(RESET_CYCLES - 1);
    localparam logic [WW-1:0] SET_END  = WW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] GAP_END  = WW'(2 * CLK_DIV - 1);
    localparam logic [13:0]   LAST_PIX = 14'(PIXELS - 1);

    typedef enum logic [2:0] {
        PWR_RST,
        PWR_WAIT,
        INIT,
        GAP,
        FRAME
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    bit_cnt;
    logic [3:0]    byte_idx;
    logic [15:0]   shreg;
    logic          inc_pend;

    logic [3:0]    rom_idx;
    logic [7:0]    rom_byte;
    logic [3:0]    last_bit;

    function automatic logic [7:0] init_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'hAE;
            4'd1:    b = 8'hA0;
            4'd2:    b = 8'h72;
            4'd3:    b = 8'h15;
            4'd4:    b = 8'h00;
            4'd5:    b = 8'h5F;
            4'd6:    b = 8'h75;
            4'd7:    b = 8'h00;
            4'd8:    b = 8'h3F;
            4'd9:    b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next init byte to load and the final bit position of the current word
    always_comb begin
        rom_idx  = (state == INIT) ? byte_idx + 4'd1 : 4'd0;
        rom_byte = init_byte(rom_idx);
        last_bit = (state == FRAME) ? 4'd15 : 4'd7;
    end

    // Sequencer, SCLK divider and shift engine; loads happen on falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PWR_RST;
            div_cnt     <= '0;
            wait_cnt    <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            shreg       <= '0;
            inc_pend    <= 1'b0;
            pixel_index <= '0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            cs_n        <= 1'b1;
            dc          <= 1'b0;
            res_n       <= 1'b0;
            frame_begin <= 1'b0;
            ready       <= 1'b0;
        end else begin
            frame_begin <= 1'b0;
            inc_pend    <= 1'b0;
            if (inc_pend)
                pixel_index <= (pixel_index == LAST_PIX) ? 14'd0 : pixel_index + 14'd1;
            case (state)
                PWR_RST: begin
                    if (wait_cnt == RST_END) begin
                        wait_cnt <= '0;
                        res_n    <= 1'b1;
                        state    <= PWR_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PWR_WAIT: begin
                    if (wait_cnt == SET_END) begin
                        wait_cnt <= '0;
                        state    <= INIT;
                        cs_n     <= 1'b0;
                        dc       <= 1'b0;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        div_cnt  <= '0;
                        sclk     <= 1'b0;
                        shreg    <= {rom_byte, 8'h00};
                        mosi     <= rom_byte[7];
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                INIT, FRAME: begin
                    if (div_cnt != DIV_END) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt != last_bit) begin
                                bit_cnt <= bit_cnt + 4'd1;
                                shreg   <= {shreg[14:0], 1'b0};
                                mosi    <= shreg[14];
                            end else begin
                                bit_cnt <= '0;
                                if (state == INIT && byte_idx != 4'd9) begin
                                    byte_idx <= byte_idx + 4'd1;
                                    shreg    <= {rom_byte, 8'h00};
                                    mosi     <= rom_byte[7];
                                end else if (state == FRAME && pixel_index != 14'd0) begin
                                    shreg    <= pixel_data;
                                    mosi     <= pixel_data[15];
                                    inc_pend <= 1'b1;
                                end else begin
                                    // pixel_index already wrapped: frame done
                                    state    <= GAP;
                                    cs_n     <= 1'b1;
                                    mosi     <= 1'b0;
                                    wait_cnt <= '0;
                                    byte_idx <= '0;
                                    ready    <= 1'b1;
                                end
                            end
                        end
                    end
                end
                GAP: begin
                    if (wait_cnt == GAP_END) begin
                        wait_cnt    <= '0;
                        state       <= FRAME;
                        cs_n        <= 1'b0;
                        dc          <= 1'b1;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        shreg       <= pixel_data;
                        mosi        <= pixel_data[15];
                        inc_pend    <= 1'b1;
                        frame_begin <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= PWR_RST;
            endcase
        end
    end

endmodule
